// File: rtl/pingpong_frame_buffer.sv
// Ping-pong capture buffer between the ADC front end and the FFT engine.
// Writes fill one bank while the reader drains the other; the reader sets the pace.
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   arm, mode_single         restart capture / single-shot select
//   din_valid, din           packed NCH x DW sample input
//   frame_ready, frame_bank  full bank presented to the reader
//   frame_done               reader releases the presented bank
//   rd_en, rd_addr           read request into the presented bank
//   rd_data, rd_valid        read data, one cycle after rd_en
//   wr_bank, wr_count, busy  writer status
//   overflow, drop_cnt       dropped-sample accounting
module pingpong_frame_buffer #(
    parameter int DW         = 10,
    parameter int NCH        = 1,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH),
    parameter int OFFSET_BIN = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              arm,
    input  logic              mode_single,
    input  logic              din_valid,
    input  logic [NCH*DW-1:0] din,
    output logic              frame_ready,
    output logic              frame_bank,
    input  logic              frame_done,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [NCH*DW-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_bank,
    output logic [AW-1:0]     wr_count,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_WAIT
    } wstate_t;

    wstate_t           r_state, w_state_n;
    logic [1:0]        r_full, w_full_n;
    logic              r_wr_bank, w_wr_bank_n;
    logic              r_rd_bank, w_rd_bank_n;
    logic [AW-1:0]     r_wr_count, w_wr_count_n;
    logic              r_overflow, w_overflow_n;
    logic [15:0]       r_drop_cnt, w_drop_cnt_n;
    logic [NCH*DW-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [NCH*DW-1:0] r_mem [0:2*DEPTH-1];

    logic              w_frame_ready;
    logic              w_done_acc;
    logic              w_other_free;
    logic              w_wr_fire;
    logic [NCH*DW-1:0] w_conv;

    assign w_frame_ready = r_full[r_rd_bank];
    assign w_done_acc    = frame_done & w_frame_ready;
    // A release of the other bank in this same cycle counts as free,
    // so a reader that finishes exactly on time causes no drops.
    assign w_other_free  = !r_full[~r_wr_bank] ||
                           (w_done_acc && (r_rd_bank == ~r_wr_bank));
    assign w_wr_fire     = (r_state == W_FILL) && din_valid && !arm;

    // Offset-binary to two's complement: flip each channel MSB.
    always_comb begin
        w_conv = din;
        if (OFFSET_BIN != 0) begin
            for (int c = 0; c < NCH; c++) begin
                w_conv[c*DW+DW-1] = ~din[c*DW+DW-1];
            end
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_full_n     = r_full;
        w_wr_bank_n  = r_wr_bank;
        w_rd_bank_n  = r_rd_bank;
        w_wr_count_n = r_wr_count;
        w_overflow_n = r_overflow;
        w_drop_cnt_n = r_drop_cnt;
        if (arm) begin
            w_state_n    = W_FILL;
            w_full_n     = 2'b00;
            w_wr_bank_n  = 1'b0;
            w_rd_bank_n  = 1'b0;
            w_wr_count_n = '0;
            w_overflow_n = 1'b0;
            w_drop_cnt_n = '0;
        end else begin
            if (w_done_acc) begin
                w_full_n[r_rd_bank] = 1'b0;
                w_rd_bank_n         = ~r_rd_bank;
            end
            unique case (r_state)
                W_IDLE: begin
                    if (!mode_single) w_state_n = W_FILL;
                end
                W_FILL: begin
                    if (din_valid) begin
                        w_wr_count_n = r_wr_count + 1'b1;
                        if (r_wr_count == AW'(DEPTH - 1)) begin
                            w_full_n[r_wr_bank] = 1'b1;
                            if (w_other_free) begin
                                w_wr_bank_n = ~r_wr_bank;
                                w_state_n   = mode_single ? W_IDLE : W_FILL;
                            end else begin
                                w_state_n = W_WAIT;
                            end
                        end
                    end
                end
                W_WAIT: begin
                    if (din_valid) begin
                        w_overflow_n = 1'b1;
                        if (r_drop_cnt != 16'hFFFF)
                            w_drop_cnt_n = r_drop_cnt + 16'd1;
                    end
                    if (w_other_free) begin
                        w_wr_bank_n = ~r_wr_bank;
                        w_state_n   = W_FILL;
                    end
                end
                default: w_state_n = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= W_IDLE;
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_count <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_full     <= w_full_n;
            r_wr_bank  <= w_wr_bank_n;
            r_rd_bank  <= w_rd_bank_n;
            r_wr_count <= w_wr_count_n;
            r_overflow <= w_overflow_n;
            r_drop_cnt <= w_drop_cnt_n;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_fire && !sys_rst)
            r_mem[{r_wr_bank, r_wr_count}] <= w_conv;
    end

    // Reads use the pre-release bank, so a read issued with frame_done
    // still returns data from the bank being released.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (rd_en && w_frame_ready) begin
            r_rd_data  <= r_mem[{r_rd_bank, rd_addr}];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign frame_ready = w_frame_ready;
    assign frame_bank  = r_rd_bank;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign wr_bank     = r_wr_bank;
    assign wr_count    = r_wr_count;
    assign busy        = (r_state != W_IDLE);
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule
